serial_tx_arbiter: RTL

- Shares one 16-bit parallel-in/serial-out shift datapath between two requesters.
- Each requester offers a parallel word with a req/ack handshake.
- The block arbitrates round-robin, loads the winning word, shifts it out LSB-first with framing strobes, then re-arbitrates.
- Sits between word producers and a single-wire serial consumer; it is the sequencer the bare 16-bit shift register lacks.

---
 rtl/serial_tx_arbiter_pkg.sv | 27 ++
 rtl/serial_tx_arbiter_piso.sv | 38 +++
 rtl/serial_tx_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester serial transmit arbiter.
// Holds the FSM encoding, the default frame width and the round-robin pick helper.
package serial_tx_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int GAP_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Returns {grant_valid, grant_index}; on a tie the rr pointer chooses.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic rr);
    logic [1:0] res;
    res = 2'b00;
    case (req)
      2'b01:   res = 2'b10;
      2'b10:   res = 2'b11;
      2'b11:   res = {1'b1, rr};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_piso.sv
// Parallel-in/serial-out shift register: right shift with zero fill, LSB presented on q0.
// A load in the same cycle as a shift request wins.
module piso_shift_reg
  import serial_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = d;
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q0 = shift_q[0];

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one PISO datapath between two word producers.
// Grants in IDLE, shifts WIDTH bits LSB-first with framing strobes, then idles GAP_CYCLES.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [1:0]       ack_o,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             grant_id,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_d;
  logic                 rr_q;
  logic                 grant_q;

  logic [1:0]           pick;
  logic                 gnt_valid;
  logic                 gnt_idx;
  logic                 in_idle;
  logic                 in_shift;
  logic                 last_bit;
  logic                 gap_done;
  logic                 load;
  logic [WIDTH-1:0]     load_word;
  logic                 piso_q0;

  assign pick      = rr_pick(req_i, rr_q);
  assign gnt_valid = pick[1];
  assign gnt_idx   = pick[0];
  assign in_idle   = (state_q == ST_IDLE);
  assign in_shift  = (state_q == ST_SHIFT);
  assign last_bit  = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign gap_done  = (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1));
  assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
  assign gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);

  // The ack is decoded combinationally so the producer sees it in the same cycle its word is sampled.
  always_comb begin
    ack_o = 2'b00;
    if (in_idle && gnt_valid) begin
      ack_o[gnt_idx] = 1'b1;
    end
  end

  assign load      = in_idle && gnt_valid;
  assign load_word = gnt_idx ? data1_i : data0_i;

  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (in_shift),
    .d        (load_word),
    .q0       (piso_q0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      rr_q      <= 1'b0;
      grant_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_q   <= gnt_idx;
            rr_q      <= ~gnt_idx;
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            bit_cnt_q <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end else begin
              grant_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_d;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            gap_cnt_q <= '0;
            grant_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ser_out   = in_shift & piso_q0;
  assign ser_valid = in_shift;
  assign ser_last  = in_shift & last_bit;
  assign grant_id  = grant_q;
  assign busy      = ~in_idle;

endmodule
